// File: rtl/lsu_mstage.sv
// Memory stage load/store unit: one AXI4-Lite access per accepted request.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module lsu_mstage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mvalid,
  input  logic        mwen,
  input  logic [7:0]  mwmask,
  input  logic [2:0]  mrtype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] load_data,
  output logic        mem_err,
  output logic        misalign
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        mwen_q, mwen_d;
  logic [3:0]  mwmask_q, mwmask_d;
  logic [2:0]  mrtype_q, mrtype_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_err_q, mem_err_d;
  logic        misalign_q, misalign_d;
  logic        mis_in;
  logic        aw_hs, w_hs;
  logic        unused_mask_hi;

  assign unused_mask_hi = ^mwmask[7:4];

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  rt,
    input logic [31:0] rd,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (rt)
      3'd0:    ld_ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ld_ext = {{16{sh[15]}}, sh[15:0]};
      3'd2:    ld_ext = sh;
      3'd4:    ld_ext = {24'd0, sh[7:0]};
      3'd5:    ld_ext = {16'd0, sh[15:0]};
      default: ld_ext = 32'd0;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  logic is_half, is_word;
  // Access size: stores by byte mask, loads by load type
  always_comb begin
    if (mwen) begin
      is_half = (mwmask[3:0] == 4'h3);
      is_word = (mwmask[3:0] == 4'hf);
    end else begin
      is_half = (mrtype == 3'd1) || (mrtype == 3'd5);
      is_word = (mrtype == 3'd2);
    end
    mis_in = mvalid & ((is_half & addr[0]) |
                       (is_word & (|addr[1:0])));
  end
`else
  assign mis_in = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign araddr    = addr_q;
  assign arvalid   = (state_q == RD_ADDR);
  assign rready    = (state_q == RD_DATA);
  assign awaddr    = addr_q;
  assign awvalid   = (state_q == WR_REQ) & ~aw_done_q;
  assign wvalid    = (state_q == WR_REQ) & ~w_done_q;
  assign wstrb     = mwmask_q << addr_q[1:0];
  assign wdata     = wdata_q << {addr_q[1:0], 3'b000};
  assign bready    = (state_q == WR_RESP);
  assign load_data = load_data_q;
  assign mem_err   = mem_err_q;
  assign misalign  = misalign_q;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;

  // Next-state and captured-field logic
  always_comb begin
    state_d     = state_q;
    mwen_d      = mwen_q;
    mwmask_d    = mwmask_q;
    mrtype_d    = mrtype_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    load_data_d = load_data_q;
    mem_err_d   = mem_err_q;
    misalign_d  = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mwen_d      = mwen;
          mwmask_d    = mwmask[3:0];
          mrtype_d    = mrtype;
          addr_d      = addr;
          wdata_d     = wdata_in;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          load_data_d = 32'd0;
          mem_err_d   = 1'b0;
          misalign_d  = mis_in;
          if (!mvalid || mis_in) state_d = DONE;
          else if (mwen)         state_d = WR_REQ;
          else                   state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          load_data_d = ld_ext(mrtype_q, rdata, addr_q[1:0]);
          mem_err_d   = |rresp;
          state_d     = DONE;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          mem_err_d = |bresp;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          load_data_d = 32'd0;
          mem_err_d   = 1'b0;
          misalign_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and field registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mwen_q      <= 1'b0;
      mwmask_q    <= 4'd0;
      mrtype_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      load_data_q <= 32'd0;
      mem_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mwen_q      <= mwen_d;
      mwmask_q    <= mwmask_d;
      mrtype_q    <= mrtype_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      load_data_q <= load_data_d;
      mem_err_q   <= mem_err_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule
